cdb_wakeup_rs: RTL and testbench
================================

CDB_WAKEUP_RS -- requirements
Module: cdb_wakeup_rs

Interface
REQ-001 Parameter RS_DEPTH, default 8: number of reservation-station entries.
REQ-002 Parameter CDB_W, default 2: number of CDB broadcast ports.
REQ-003 Parameter XLEN, default core_pkg::XLEN: operand width.
REQ-004 Parameter PHYS_W, default core_pkg::LOG2_PREGS: physical tag width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; entries are cleared while low.
REQ-007 flush  input  1  synchronous clear of all entries, e.g. on branch mispredict.
REQ-008 disp_valid / disp_ready  input / output  1 / 1  dispatch handshake.
REQ-009 disp_op  input  6  opcode.
REQ-010 disp_dst_tag  input  PHYS_W  destination physical tag.
REQ-011 disp_rob_tag  input  6  ROB tag.
REQ-012 disp_srcN_rdy / disp_srcN_tag / disp_srcN_val  input  1 / PHYS_W / XLEN  source operand N, N=1,2.
REQ-013 cdb_valid / cdb_tag / cdb_value  input  [CDB_W] / [CDB_W][PHYS_W] / [CDB_W][XLEN]  CDB broadcast ports.
REQ-014 iss_valid / iss_ready  output / input  1 / 1  issue handshake to the functional unit.
REQ-015 iss_op, iss_src1_val, iss_src2_val, iss_dst_tag, iss_rob_tag  output  6 / XLEN / XLEN / PHYS_W / 6  issued micro-op fields.
REQ-016 occupancy  output  $clog2(RS_DEPTH)+1  count of valid entries.

Function
REQ-017 Each entry holds: valid, op, dst_tag, rob_tag, and per source a rdy bit, a tag and a value.
REQ-018 disp_ready is 1 iff occupancy < RS_DEPTH; this is a registered-state function.
REQ-019 A dispatch is accepted when disp_valid and disp_ready are both 1; it writes the lowest-index free entry at that clock edge.
REQ-020 Wakeup: every cycle, for each valid entry source with rdy=0, if cdb_valid[p] is 1 and cdb_tag[p] equals the source tag, set rdy=1 and capture cdb_value[p].
REQ-021 If several ports match the same source tag, the lowest port index wins.
REQ-022 Dispatch bypass: if a dispatched source has rdy=0 and its tag matches a valid CDB port in the same cycle, the entry is written with rdy=1 and the CDB value.
REQ-023 An entry is issuable iff valid and both source rdy bits are 1.
REQ-024 A source woken in cycle N makes the entry issuable no earlier than cycle N+1.
REQ-025 iss_valid and the iss_* fields are combinational from registered entry state only, and carry the selected issuable entry.
REQ-026 iss_valid is 0 and the iss_* fields are 0 when no entry is issuable.
REQ-027 On iss_valid and iss_ready both 1, the selected entry is freed at that clock edge.
REQ-028 The selected entry is held until iss_ready is asserted.
REQ-029 A same-cycle issue and dispatch are both performed; occupancy is unchanged.
REQ-030 A freed slot becomes dispatchable only from the next cycle; there is no same-cycle reuse when full.
REQ-031 flush clears all valid bits and sets occupancy to 0 at that clock edge.
REQ-032 flush overrides a same-cycle dispatch, issue and wakeup, and suppresses the dispatch acceptance.

Reset
REQ-033 While reset is low, all entry valid bits are 0 and occupancy is 0.
REQ-034 While reset is low, disp_ready is 1, iss_valid is 0 and all iss_* fields are 0.
REQ-035 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Configuration
REQ-036 With macro RS_AGE_ORDER_EN defined, selection picks the oldest issuable entry using a RS_DEPTH x RS_DEPTH age matrix.
REQ-037 Under RS_AGE_ORDER_EN, the age matrix is updated on dispatch (new entry is younger than all valid entries) and is cleared on reset.
REQ-038 With RS_AGE_ORDER_EN undefined, selection picks the lowest-index issuable entry and no age state exists.

Verification
REQ-039 Dispatch op=3 with src1 rdy, val=5 and src2 rdy, val=7, iss_ready=1 -> iss_valid=1 next cycle with vals 5/7, then occupancy returns to 0.
REQ-040 Dispatch src2 tag=12 not ready; 3 cycles later cdb_valid[1]=1, tag=12, value=0xAB -> iss_valid=1 the following cycle with src2_val=0xAB.
REQ-041 Dispatch src1 tag=9 not ready while the same cycle cdb tag=9 carries 0x55 -> entry issuable next cycle with src1_val=0x55 (bypass).
REQ-042 Fill 8 entries with iss_ready=0 -> disp_ready=0, occupancy=8; one issue -> disp_ready=1 the next cycle.
REQ-043 Dispatch A into entry 5, then B into entry 0, both ready, with RS_AGE_ORDER_EN -> A issues first; without the macro -> B issues first.
REQ-044 Pulse flush with 4 valid entries and a simultaneous dispatch -> occupancy=0, iss_valid=0 next cycle; assert reset mid-wakeup -> iss_valid=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide sizing constants shared by the back-end blocks.
package core_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned LOG2_PREGS = 6;
endpackage

// File: rtl/cdb_wakeup_rs_if.sv
// Dispatch, CDB broadcast, issue and occupancy bundle of the cdb_wakeup_rs reservation station.
interface cdb_wakeup_rs_if #(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned CDB_W    = 2,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PHYS_W   = 6
);
  localparam int unsigned OCC_W = $clog2(RS_DEPTH) + 1;

  logic                          disp_valid;
  logic                          disp_ready;
  logic [5:0]                    disp_op;
  logic [PHYS_W-1:0]             disp_dst_tag;
  logic [5:0]                    disp_rob_tag;
  logic                          disp_src1_rdy;
  logic [PHYS_W-1:0]             disp_src1_tag;
  logic [XLEN-1:0]               disp_src1_val;
  logic                          disp_src2_rdy;
  logic [PHYS_W-1:0]             disp_src2_tag;
  logic [XLEN-1:0]               disp_src2_val;
  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]  cdb_tag;
  logic [CDB_W-1:0][XLEN-1:0]    cdb_value;
  logic                          iss_valid;
  logic                          iss_ready;
  logic [5:0]                    iss_op;
  logic [XLEN-1:0]               iss_src1_val;
  logic [XLEN-1:0]               iss_src2_val;
  logic [PHYS_W-1:0]             iss_dst_tag;
  logic [5:0]                    iss_rob_tag;
  logic [OCC_W-1:0]              occupancy;

  modport master (
    output disp_valid, disp_op, disp_dst_tag, disp_rob_tag,
           disp_src1_rdy, disp_src1_tag, disp_src1_val,
           disp_src2_rdy, disp_src2_tag, disp_src2_val,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_src1_val, iss_src2_val,
           iss_dst_tag, iss_rob_tag, occupancy
  );

  modport slave (
    input  disp_valid, disp_op, disp_dst_tag, disp_rob_tag,
           disp_src1_rdy, disp_src1_tag, disp_src1_val,
           disp_src2_rdy, disp_src2_tag, disp_src2_val,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_src1_val, iss_src2_val,
           iss_dst_tag, iss_rob_tag, occupancy
  );
endinterface

// File: rtl/cdb_wakeup_rs.sv
// Reservation station with CDB wakeup, dispatch bypass and single-issue select.
// Macro RS_AGE_ORDER_EN selects oldest-first issue via an age matrix; otherwise lowest index wins.
module cdb_wakeup_rs #(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned CDB_W    = 2,
  parameter int unsigned XLEN     = core_pkg::XLEN,
  parameter int unsigned PHYS_W   = core_pkg::LOG2_PREGS
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  cdb_wakeup_rs_if.slave bus
);
  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int unsigned CP_W  = (CDB_W > 1) ? $clog2(CDB_W) : 1;
  localparam int unsigned OCC_W = $clog2(RS_DEPTH) + 1;

  logic [RS_DEPTH-1:0] valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
  logic [5:0]          op_q  [RS_DEPTH];
  logic [5:0]          op_d  [RS_DEPTH];
  logic [5:0]          rob_q [RS_DEPTH];
  logic [5:0]          rob_d [RS_DEPTH];
  logic [PHYS_W-1:0]   dst_q [RS_DEPTH];
  logic [PHYS_W-1:0]   dst_d [RS_DEPTH];
  logic [PHYS_W-1:0]   t1_q  [RS_DEPTH];
  logic [PHYS_W-1:0]   t1_d  [RS_DEPTH];
  logic [PHYS_W-1:0]   t2_q  [RS_DEPTH];
  logic [PHYS_W-1:0]   t2_d  [RS_DEPTH];
  logic [XLEN-1:0]     v1_q  [RS_DEPTH];
  logic [XLEN-1:0]     v1_d  [RS_DEPTH];
  logic [XLEN-1:0]     v2_q  [RS_DEPTH];
  logic [XLEN-1:0]     v2_d  [RS_DEPTH];

  logic [OCC_W-1:0]    occ_c;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic [RS_DEPTH-1:0] issuable;
  logic                disp_ready_c, disp_fire, iss_fire;

  // Capture a CDB result for a pending source; lowest matching port has priority.
  function automatic logic [XLEN:0] wake(
    input logic                         rdy,
    input logic [PHYS_W-1:0]            tag,
    input logic [XLEN-1:0]              val,
    input logic [CDB_W-1:0]             cv,
    input logic [CDB_W-1:0][PHYS_W-1:0] ct,
    input logic [CDB_W-1:0][XLEN-1:0]   cval
  );
    logic [XLEN:0] res;
    res = {rdy, val};
    if (!rdy) begin
      for (int p = int'(CDB_W) - 1; p >= 0; p--) begin
        if (cv[CP_W'(p)] && (ct[CP_W'(p)] == tag)) res = {1'b1, cval[CP_W'(p)]};
      end
    end
    return res;
  endfunction

  always_comb begin : occ_and_free
    occ_c    = '0;
    free_idx = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      occ_c = occ_c + OCC_W'(valid_q[IDX_W'(i)]);
      if (!valid_q[IDX_W'(i)]) free_idx = IDX_W'(i);
    end
  end

  assign issuable     = valid_q & r1_q & r2_q;
  assign disp_ready_c = (occ_c < OCC_W'(RS_DEPTH));
  assign disp_fire    = bus.disp_valid & disp_ready_c & ~flush;
  assign iss_fire     = sel_valid & bus.iss_ready;

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] set means entry i was dispatched before entry j.
  logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] age_d [RS_DEPTH];

  always_comb begin : sel_oldest
    logic older;
    older     = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      older = 1'b0;
      for (int j = 0; j < int'(RS_DEPTH); j++) begin
        if (issuable[IDX_W'(j)] && age_q[IDX_W'(j)][IDX_W'(i)]) older = 1'b1;
      end
      if (issuable[IDX_W'(i)] && !older) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin : age_next
    age_d = age_q;
    if (disp_fire) begin
      for (int j = 0; j < int'(RS_DEPTH); j++) age_d[IDX_W'(j)][free_idx] = 1'b1;
      age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin : age_reg
    if (!reset) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) age_q[IDX_W'(i)] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin : sel_lowest
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (issuable[IDX_W'(i)]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Next entry state: wakeup, then issue free, then dispatch write; flush overrides all.
  always_comb begin : next_state
    logic [XLEN:0] w;
    w       = '0;
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    op_d    = op_q;
    rob_d   = rob_q;
    dst_d   = dst_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (valid_q[IDX_W'(i)]) begin
        w = wake(r1_q[IDX_W'(i)], t1_q[IDX_W'(i)], v1_q[IDX_W'(i)],
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        r1_d[IDX_W'(i)] = w[XLEN];
        v1_d[IDX_W'(i)] = w[XLEN-1:0];
        w = wake(r2_q[IDX_W'(i)], t2_q[IDX_W'(i)], v2_q[IDX_W'(i)],
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        r2_d[IDX_W'(i)] = w[XLEN];
        v2_d[IDX_W'(i)] = w[XLEN-1:0];
      end
    end
    if (iss_fire) valid_d[sel_idx] = 1'b0;
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = bus.disp_op;
      rob_d[free_idx]   = bus.disp_rob_tag;
      dst_d[free_idx]   = bus.disp_dst_tag;
      t1_d[free_idx]    = bus.disp_src1_tag;
      t2_d[free_idx]    = bus.disp_src2_tag;
      w = wake(bus.disp_src1_rdy, bus.disp_src1_tag, bus.disp_src1_val,
               bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      r1_d[free_idx] = w[XLEN];
      v1_d[free_idx] = w[XLEN-1:0];
      w = wake(bus.disp_src2_rdy, bus.disp_src2_tag, bus.disp_src2_val,
               bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      r2_d[free_idx] = w[XLEN];
      v2_d[free_idx] = w[XLEN-1:0];
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin : entry_reg
    if (!reset) begin
      valid_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        op_q[IDX_W'(i)]  <= '0;
        rob_q[IDX_W'(i)] <= '0;
        dst_q[IDX_W'(i)] <= '0;
        t1_q[IDX_W'(i)]  <= '0;
        t2_q[IDX_W'(i)]  <= '0;
        v1_q[IDX_W'(i)]  <= '0;
        v2_q[IDX_W'(i)]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      op_q    <= op_d;
      rob_q   <= rob_d;
      dst_q   <= dst_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
    end
  end

  // Issue port is driven from registered entry state only; zero when nothing is issuable.
  always_comb begin : issue_out
    bus.iss_valid    = sel_valid;
    bus.iss_op       = '0;
    bus.iss_src1_val = '0;
    bus.iss_src2_val = '0;
    bus.iss_dst_tag  = '0;
    bus.iss_rob_tag  = '0;
    if (sel_valid) begin
      bus.iss_op       = op_q[sel_idx];
      bus.iss_src1_val = v1_q[sel_idx];
      bus.iss_src2_val = v2_q[sel_idx];
      bus.iss_dst_tag  = dst_q[sel_idx];
      bus.iss_rob_tag  = rob_q[sel_idx];
    end
  end

  assign bus.disp_ready = disp_ready_c;
  assign bus.occupancy  = occ_c;
endmodule

// File: tb/tb_cdb_wakeup_rs.sv
// Self-checking bench for cdb_wakeup_rs: directed scenarios plus a randomized run against a queue-style model.
module tb_cdb_wakeup_rs;
  localparam int D  = 8;
  localparam int CW = 2;
  localparam int XL = 32;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  cdb_wakeup_rs_if #(.RS_DEPTH(D), .CDB_W(CW), .XLEN(XL), .PHYS_W(PW)) bus ();
  cdb_wakeup_rs #(.RS_DEPTH(D), .CDB_W(CW), .XLEN(XL), .PHYS_W(PW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [5:0]  dst;
    logic [5:0]  rob;
    bit          r1;
    logic [5:0]  t1;
    logic [31:0] v1;
    bit          r2;
    logic [5:0]  t2;
    logic [31:0] v2;
    int unsigned seq;
  } ent_t;

  ent_t        m [D];
  int unsigned seq_ctr = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Model: entry chosen for issue (oldest dispatch when age ordering is built in).
  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < D; i++) begin
      if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_ORDER_EN
        if (s < 0 || m[i].seq < m[s].seq) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < D; i++) if (m[i].v) n++;
    return n;
  endfunction

  function automatic logic [32:0] m_wake(bit r, logic [5:0] tag, logic [31:0] val);
    if (r) return {1'b1, val};
    for (int p = 0; p < CW; p++)
      if (bus.cdb_valid[p] && bus.cdb_tag[p] == tag) return {1'b1, bus.cdb_value[p]};
    return {1'b0, val};
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < D; i++) m[i].v = 1'b0;
  endfunction

  // Advance one clock, updating the model from the inputs applied during this cycle.
  task automatic tick();
    ent_t        n [D];
    int          s;
    int          fr;
    bit          acc;
    logic [32:0] w;
    n  = m;
    s  = m_sel();
    fr = -1;
    for (int i = D - 1; i >= 0; i--) if (!m[i].v) fr = i;
    acc = bus.disp_valid && (fr >= 0) && !flush;
    for (int i = 0; i < D; i++) begin
      if (m[i].v) begin
        w = m_wake(m[i].r1, m[i].t1, m[i].v1); n[i].r1 = w[32]; n[i].v1 = w[31:0];
        w = m_wake(m[i].r2, m[i].t2, m[i].v2); n[i].r2 = w[32]; n[i].v2 = w[31:0];
      end
    end
    if (s >= 0 && bus.iss_ready) n[s].v = 1'b0;
    if (acc) begin
      n[fr].v   = 1'b1;
      n[fr].op  = bus.disp_op;
      n[fr].dst = bus.disp_dst_tag;
      n[fr].rob = bus.disp_rob_tag;
      n[fr].t1  = bus.disp_src1_tag;
      n[fr].t2  = bus.disp_src2_tag;
      w = m_wake(bus.disp_src1_rdy, bus.disp_src1_tag, bus.disp_src1_val);
      n[fr].r1 = w[32]; n[fr].v1 = w[31:0];
      w = m_wake(bus.disp_src2_rdy, bus.disp_src2_tag, bus.disp_src2_val);
      n[fr].r2 = w[32]; n[fr].v2 = w[31:0];
      n[fr].seq = seq_ctr;
      seq_ctr++;
    end
    if (flush) for (int i = 0; i < D; i++) n[i].v = 1'b0;
    @(posedge clk);
    #1;
    if (reset) m = n;
    else m_clear();
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.disp_op = '0; bus.disp_dst_tag = '0; bus.disp_rob_tag = '0;
    bus.disp_src1_rdy = 1'b0; bus.disp_src1_tag = '0; bus.disp_src1_val = '0;
    bus.disp_src2_rdy = 1'b0; bus.disp_src2_tag = '0; bus.disp_src2_val = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.iss_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [5:0] dst, input logic [5:0] rob,
                          input bit r1, input logic [5:0] t1, input logic [31:0] v1,
                          input bit r2, input logic [5:0] t2, input logic [31:0] v2);
    bus.disp_valid = 1'b1;
    bus.disp_op = op; bus.disp_dst_tag = dst; bus.disp_rob_tag = rob;
    bus.disp_src1_rdy = r1; bus.disp_src1_tag = t1; bus.disp_src1_val = v1;
    bus.disp_src2_rdy = r2; bus.disp_src2_tag = t2; bus.disp_src2_val = v2;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    set_disp(6'd1, 6'd1, 6'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    #1;
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready got=%b exp=1", bus.disp_ready); end
    n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL reset_iss_valid got=%b exp=0", bus.iss_valid); end
    n_cmp++; if ({bus.iss_op, bus.iss_src1_val, bus.iss_src2_val, bus.iss_dst_tag, bus.iss_rob_tag} !== '0) begin
      n_err++; $display("FAIL reset_iss_fields got op=%h s1=%h s2=%h exp=0", bus.iss_op, bus.iss_src1_val, bus.iss_src2_val); end
    @(posedge clk); #1;
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL reset_hold_occ got=%0d exp=0", bus.occupancy); end
    m_clear();
    idle();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL reset_release_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_basic_issue();
    idle();
    bus.iss_ready = 1'b1;
    set_disp(6'd3, 6'd1, 6'd2, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    tick();
    bus.disp_valid = 1'b0;
    n_cmp++; if (bus.iss_valid !== 1'b1) begin n_err++; $display("FAIL basic_iss_valid got=%b exp=1", bus.iss_valid); end
    n_cmp++; if ({bus.iss_op, bus.iss_src1_val, bus.iss_src2_val, bus.iss_dst_tag, bus.iss_rob_tag} !== {6'd3, 32'd5, 32'd7, 6'd1, 6'd2}) begin
      n_err++; $display("FAIL basic_fields got op=%0d s1=%0d s2=%0d dst=%0d rob=%0d exp 3/5/7/1/2",
                        bus.iss_op, bus.iss_src1_val, bus.iss_src2_val, bus.iss_dst_tag, bus.iss_rob_tag); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL basic_drain_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain_iss_valid got=%b exp=0", bus.iss_valid); end
  endtask

  task automatic test_wakeup();
    idle();
    bus.iss_ready = 1'b1;
    set_disp(6'd4, 6'd3, 6'd4, 1'b1, 6'd0, 32'd1, 1'b0, 6'd12, 32'd0);
    tick();
    bus.disp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus.cdb_valid = 2'b10;
        bus.cdb_tag[0] = 6'd12; bus.cdb_value[0] = 32'h77;
        bus.cdb_tag[1] = 6'd12; bus.cdb_value[1] = 32'hAB;
      end
      n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL wake_wait%0d_iss_valid got=%b exp=0", k, bus.iss_valid); end
      tick();
    end
    idle();
    bus.iss_ready = 1'b1;
    n_cmp++; if (bus.iss_valid !== 1'b1) begin n_err++; $display("FAIL wake_iss_valid got=%b exp=1", bus.iss_valid); end
    n_cmp++; if (bus.iss_src2_val !== 32'hAB) begin n_err++; $display("FAIL wake_src2_val got=%h exp=ab", bus.iss_src2_val); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL wake_drain_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_bypass();
    idle();
    set_disp(6'd5, 6'd6, 6'd7, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd3);
    bus.cdb_valid = 2'b11;
    bus.cdb_tag[0] = 6'd9; bus.cdb_value[0] = 32'h55;
    bus.cdb_tag[1] = 6'd9; bus.cdb_value[1] = 32'h66;
    tick();
    idle();
    n_cmp++; if (bus.iss_valid !== 1'b1) begin n_err++; $display("FAIL bypass_iss_valid got=%b exp=1", bus.iss_valid); end
    n_cmp++; if (bus.iss_src1_val !== 32'h55) begin n_err++; $display("FAIL bypass_src1_val got=%h exp=55", bus.iss_src1_val); end
    bus.iss_ready = 1'b1;
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL bypass_drain_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < D; i++) begin
      set_disp(6'(i + 1), 6'(i), 6'(i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i + 100));
      tick();
    end
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ got=%0d exp=8", bus.occupancy); end
    n_cmp++; if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_disp_ready got=%b exp=0", bus.disp_ready); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_err++; $display("FAIL full_reject_occ got=%0d exp=8", bus.occupancy); end
    n_cmp++; if (bus.iss_op !== 6'd1) begin n_err++; $display("FAIL full_sel_op got=%0d exp=1", bus.iss_op); end
    bus.iss_ready = 1'b1;
    tick();
    n_cmp++; if (bus.occupancy !== 4'd7) begin n_err++; $display("FAIL full_noreuse_occ got=%0d exp=7", bus.occupancy); end
    n_cmp++; if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen_disp_ready got=%b exp=1", bus.disp_ready); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd7) begin n_err++; $display("FAIL full_iss_and_disp_occ got=%0d exp=7", bus.occupancy); end
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL full_flush_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_age_order();
    logic [5:0] exp_first, exp_second;
    idle();
    set_disp(6'h10, 6'd0, 6'd0, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
    tick();
    for (int k = 1; k < 5; k++) begin
      set_disp(6'(32 + k), 6'(k), 6'(k), 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd0);
      tick();
    end
    set_disp(6'h0A, 6'd5, 6'd5, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 32'hA2);
    tick();
    bus.disp_valid = 1'b0;
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    n_cmp++; if (bus.occupancy !== 4'd5) begin n_err++; $display("FAIL age_setup_occ got=%0d exp=5", bus.occupancy); end
    set_disp(6'h0B, 6'd6, 6'd6, 1'b1, 6'd0, 32'hB1, 1'b1, 6'd0, 32'hB2);
    tick();
    bus.disp_valid = 1'b0;
`ifdef RS_AGE_ORDER_EN
    exp_first = 6'h0A; exp_second = 6'h0B;
`else
    exp_first = 6'h0B; exp_second = 6'h0A;
`endif
    n_cmp++; if (bus.iss_op !== exp_first) begin n_err++; $display("FAIL age_first_op got=%h exp=%h", bus.iss_op, exp_first); end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    n_cmp++; if (bus.iss_op !== exp_second) begin n_err++; $display("FAIL age_second_op got=%h exp=%h", bus.iss_op, exp_second); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(6'(i), 6'(i), 6'(i), 1'b1, 6'd0, 32'(i), 1'b0, 6'd30, 32'd0);
      tick();
    end
    n_cmp++; if (bus.occupancy !== 4'd4) begin n_err++; $display("FAIL flush_setup_occ got=%0d exp=4", bus.occupancy); end
    set_disp(6'd9, 6'd9, 6'd9, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    bus.cdb_valid = 2'b01; bus.cdb_tag[0] = 6'd30; bus.cdb_value[0] = 32'h1234;
    bus.iss_ready = 1'b1;
    flush = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL flush_iss_valid got=%b exp=0", bus.iss_valid); end
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL flush_after_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_reset_mid();
    idle();
    set_disp(6'd1, 6'd1, 6'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    tick();
    set_disp(6'd2, 6'd2, 6'd2, 1'b1, 6'd0, 32'd2, 1'b0, 6'd20, 32'd0);
    tick();
    bus.disp_valid = 1'b0;
    n_cmp++; if (bus.iss_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_iss_valid got=%b exp=1", bus.iss_valid); end
    bus.cdb_valid = 2'b01; bus.cdb_tag[0] = 6'd20; bus.cdb_value[0] = 32'h99;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_iss_valid got=%b exp=0", bus.iss_valid); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL rstmid_occ got=%0d exp=0", bus.occupancy); end
    n_cmp++; if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_disp_ready got=%b exp=1", bus.disp_ready); end
    m_clear();
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_err++; $display("FAIL rstmid_release_occ got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_random();
    int s;
    logic [81:0] exp_f;
    idle();
    for (int c = 0; c < 800; c++) begin
      s = m_sel();
      exp_f = (s >= 0) ? {m[s].op, m[s].v1, m[s].v2, m[s].dst, m[s].rob} : '0;
      n_cmp++; if (bus.iss_valid !== (s >= 0)) begin n_err++; $display("FAIL rand_iss_valid cyc=%0d got=%b exp=%b", c, bus.iss_valid, s >= 0); end
      n_cmp++; if ({bus.iss_op, bus.iss_src1_val, bus.iss_src2_val, bus.iss_dst_tag, bus.iss_rob_tag} !== exp_f) begin
        n_err++; $display("FAIL rand_iss_fields cyc=%0d got=%h exp=%h", c,
                          {bus.iss_op, bus.iss_src1_val, bus.iss_src2_val, bus.iss_dst_tag, bus.iss_rob_tag}, exp_f); end
      n_cmp++; if (bus.occupancy !== 4'(m_occ())) begin n_err++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, bus.occupancy, m_occ()); end
      n_cmp++; if (bus.disp_ready !== (m_occ() < D)) begin n_err++; $display("FAIL rand_disp_ready cyc=%0d got=%b exp=%b", c, bus.disp_ready, m_occ() < D); end
      set_disp(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
               $urandom_range(0, 2) == 0, 6'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 2) == 0, 6'($urandom_range(0, 7)), $urandom);
      bus.disp_valid = ($urandom_range(0, 9) < 6);
      for (int p = 0; p < CW; p++) begin
        bus.cdb_valid[p] = ($urandom_range(0, 1) == 1);
        bus.cdb_tag[p]   = 6'($urandom_range(0, 7));
        bus.cdb_value[p] = $urandom;
      end
      bus.iss_ready = (c < 400) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    for (int i = 0; i < D; i++) m[i] = '{default: 0};
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_full();
    test_age_order();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
